// File: rtl/lcd_write_sequencer.sv
//============================================================================
// Module      : lcd_write_sequencer
// Description : Turns each CPU store to the LCD PIO register into a timed
//               HD44780-style write cycle (setup, EN pulse, hold, exec wait).
//               A one-deep pending buffer absorbs a back-to-back store; a
//               sticky overrun flag records any store that had to be dropped.
//
// Ports       : i_clk        system clock
//               i_reset      asynchronous reset, active-high
//               i_lcd_req    one-cycle strobe, CPU store to LCD register
//               i_lcd_wdata  store data: [31]=ON, [8]=RS, [7:0]=DATA
//               i_clr_ovr    clear sticky overrun flag
//               o_lcd_data   LCD data bus
//               o_lcd_rs     register select (0=command, 1=data)
//               o_lcd_rw     read/write, tied to write (0)
//               o_lcd_en     enable strobe
//               o_lcd_on     LCD power/backlight
//               o_busy       write in flight or pending
//               o_overrun    sticky, a request was dropped
//
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module lcd_write_sequencer #(
    parameter int SETUP_CYC     = 3,
    parameter int PULSE_CYC     = 25,
    parameter int HOLD_CYC      = 3,
    parameter int EXEC_CYC      = 2500,
    parameter int LONG_EXEC_CYC = 82000,
    parameter int CNT_W         = 17
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_lcd_req,
    input  logic [31:0] i_lcd_wdata,
    input  logic        i_clr_ovr,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_en,
    output logic        o_lcd_on,
    output logic        o_busy,
    output logic        o_overrun
);

    //------------------------------------------------------------------------
    // State encoding
    //------------------------------------------------------------------------
    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_SETUP = 3'd1;
    localparam logic [2:0] c_ST_PULSE = 3'd2;
    localparam logic [2:0] c_ST_HOLD  = 3'd3;
    localparam logic [2:0] c_ST_EXEC  = 3'd4;

    // Counter load values: a state of N cycles loads N-1 on entry and
    // leaves on the cycle the counter reads zero.
    localparam logic [CNT_W-1:0] c_SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] c_PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] c_HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] c_EXEC_LD  = CNT_W'(EXEC_CYC - 1);
    localparam logic [CNT_W-1:0] c_LONG_LD  = CNT_W'(LONG_EXEC_CYC - 1);

    //------------------------------------------------------------------------
    // Registers
    //------------------------------------------------------------------------
    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pend_valid;
    logic [9:0]       r_pend_entry;    // {ON, RS, DATA}
    logic [7:0]       r_lcd_data;
    logic             r_lcd_rs;
    logic             r_lcd_on;
    logic             r_lcd_en;
    logic             r_long;          // current write needs the long exec wait
    logic             r_overrun;

    //------------------------------------------------------------------------
    // Combinational next-state signals
    //------------------------------------------------------------------------
    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_cnt_zero;
    logic [9:0]       w_req_entry;
    logic             w_launch;
    logic             w_launch_from_pend;
    logic [9:0]       w_launch_entry;
    logic             w_launch_long;
    logic             w_pend_pop;
    logic             w_req_direct;
    logic             w_pend_store;
    logic             w_drop;
    logic             w_pend_valid_nxt;

    // Only ON, RS and DATA are meaningful; the remaining store bits are
    // deliberately discarded.
    logic w_unused_wdata;
    assign w_unused_wdata = ^i_lcd_wdata[30:9];

    assign w_req_entry = {i_lcd_wdata[31], i_lcd_wdata[8], i_lcd_wdata[7:0]};
    assign w_cnt_zero  = (r_cnt == '0);

    //------------------------------------------------------------------------
    // Next-state / counter logic
    //------------------------------------------------------------------------
    always_comb begin
        w_state_nxt        = r_state;
        w_cnt_nxt          = r_cnt;
        w_launch           = 1'b0;
        w_launch_from_pend = 1'b0;
        w_pend_pop         = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                // A pending entry can only be present here if it was stored
                // in the final EXEC cycle while the slot was empty; it has
                // priority over a fresh request, which then takes the slot.
                if (r_pend_valid) begin
                    w_launch           = 1'b1;
                    w_launch_from_pend = 1'b1;
                    w_pend_pop         = 1'b1;
                end else if (i_lcd_req) begin
                    w_launch = 1'b1;
                end
            end

            c_ST_SETUP: begin
                if (w_cnt_zero) begin
                    w_state_nxt = c_ST_PULSE;
                    w_cnt_nxt   = c_PULSE_LD;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end

            c_ST_PULSE: begin
                if (w_cnt_zero) begin
                    w_state_nxt = c_ST_HOLD;
                    w_cnt_nxt   = c_HOLD_LD;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end

            c_ST_HOLD: begin
                if (w_cnt_zero) begin
                    w_state_nxt = c_ST_EXEC;
                    w_cnt_nxt   = r_long ? c_LONG_LD : c_EXEC_LD;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end

            c_ST_EXEC: begin
                if (w_cnt_zero) begin
                    // Chain straight into the next write when one is
                    // waiting, so there is no idle cycle between them.
                    if (r_pend_valid) begin
                        w_launch           = 1'b1;
                        w_launch_from_pend = 1'b1;
                        w_pend_pop         = 1'b1;
                    end else begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        if (w_launch) begin
            w_state_nxt = c_ST_SETUP;
            w_cnt_nxt   = c_SETUP_LD;
        end
    end

    assign w_launch_entry = w_launch_from_pend ? r_pend_entry : w_req_entry;

    // Clear display (0x01) and return home (0x02/0x03) need the long wait.
    assign w_launch_long = ~w_launch_entry[8]
                         & (w_launch_entry[7:2] == 6'd0)
                         & (w_launch_entry[1:0] != 2'd0);

    //------------------------------------------------------------------------
    // Pending buffer and overrun
    //------------------------------------------------------------------------
    // A request goes straight to the pins only from a truly idle sequencer;
    // otherwise it needs the slot, which is also free when the pending entry
    // is being consumed in this same cycle.
    assign w_req_direct = i_lcd_req & (r_state == c_ST_IDLE) & ~r_pend_valid;
    assign w_pend_store = i_lcd_req & ~w_req_direct & (~r_pend_valid | w_pend_pop);
    assign w_drop       = i_lcd_req & ~w_req_direct & r_pend_valid & ~w_pend_pop;

    assign w_pend_valid_nxt = w_pend_store | (r_pend_valid & ~w_pend_pop);

    //------------------------------------------------------------------------
    // Sequential state
    //------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= c_ST_IDLE;
            r_cnt        <= '0;
            r_pend_valid <= 1'b0;
            r_pend_entry <= '0;
            r_lcd_data   <= '0;
            r_lcd_rs     <= 1'b0;
            r_lcd_on     <= 1'b0;
            r_lcd_en     <= 1'b0;
            r_long       <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            if (w_pend_store) begin
                r_pend_entry <= w_req_entry;
            end
            // Pin values are captured on launch and held until the next one.
            if (w_launch) begin
                r_lcd_on   <= w_launch_entry[9];
                r_lcd_rs   <= w_launch_entry[8];
                r_lcd_data <= w_launch_entry[7:0];
                r_long     <= w_launch_long;
            end
            // EN is registered from the next state so it is glitch-free and
            // high exactly while the FSM sits in PULSE.
            r_lcd_en  <= (w_state_nxt == c_ST_PULSE);
            // A drop in the same cycle as a clear leaves the flag set.
            r_overrun <= w_drop | (r_overrun & ~i_clr_ovr);
        end
    end

    //------------------------------------------------------------------------
    // Outputs
    //------------------------------------------------------------------------
    assign o_lcd_data = r_lcd_data;
    assign o_lcd_rs   = r_lcd_rs;
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_en   = r_lcd_en;
    assign o_lcd_on   = r_lcd_on;
    assign o_busy     = (r_state != c_ST_IDLE) | r_pend_valid;
    assign o_overrun  = r_overrun;

endmodule

`default_nettype wire
